// File: rtl/i2c_ctrl_fifo_regs.sv
// -----------------------------------------------------------------------------
// i2c_ctrl_fifo_regs
//
// Processor-facing register block for the I2C master. It maps control, byte
// count, slave address and status registers onto a simple chip-select bus.
// It also provides a TX byte FIFO and an RX byte FIFO with valid/ready
// handshakes towards the master, plus a maskable sticky interrupt.
//
// Register map (byte addresses, upper address bits must be zero):
//   0x00 CTRL     RW   [6:0] control_reg, [7] FLUSH (write-only, self-clearing)
//   0x04 COUNT    RW   data_count
//   0x08 SADDR    RW   slave_addr
//   0x0C STATUS   RO   [7:0] status_reg, [8] tx_full, [9] tx_empty,
//                      [10] rx_full, [11] rx_empty, [23:16] tx level,
//                      [31:24] rx level
//   0x10 TXDATA   WO   push wdata[7:0]
//   0x14 RXDATA   RO   pop one byte (0 and RX_UNF when empty)
//   0x18 IRQ_EN   RW   [4:0]
//   0x1C IRQ_STAT W1C  [4:0] = {DONE, RX_UNF, TX_OVF, RX_AVAIL, TX_EMPTY}
//
// Ports:
//   CLK, rstn                      clock, asynchronous active-low reset
//   chip_sel/chip_en/chip_write    bus access qualifiers
//   chip_addr, wdata, rdata        bus address, write data, registered read data
//   status_reg                     raw master status, bit0 = transfer done
//   control_reg/slave_addr/data_count  configuration towards the master
//   tx_data/tx_valid/tx_ready      TX FIFO head (first-word-fall-through)
//   rx_data/rx_valid/rx_ready      RX FIFO input
//   irq                            registered OR of IRQ_STAT & IRQ_EN
// -----------------------------------------------------------------------------
module i2c_ctrl_fifo_regs #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic              CLK,
   input  logic              rstn,
   input  logic              chip_sel,
   input  logic              chip_en,
   input  logic              chip_write,
   input  logic [ADDR_W-1:0] chip_addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   input  logic [7:0]        status_reg,
   output logic [7:0]        control_reg,
   output logic [7:0]        slave_addr,
   output logic [7:0]        data_count,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              irq
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned PTR_W = CNT_W - 1;

   localparam logic [CNT_W-1:0]  DEPTH_L  = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0]  LVL_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);

   localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(8'h00);
   localparam logic [ADDR_W-1:0] A_COUNT  = ADDR_W'(8'h04);
   localparam logic [ADDR_W-1:0] A_SADDR  = ADDR_W'(8'h08);
   localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(8'h0C);
   localparam logic [ADDR_W-1:0] A_TXDATA = ADDR_W'(8'h10);
   localparam logic [ADDR_W-1:0] A_RXDATA = ADDR_W'(8'h14);
   localparam logic [ADDR_W-1:0] A_IRQEN  = ADDR_W'(8'h18);
   localparam logic [ADDR_W-1:0] A_IRQST  = ADDR_W'(8'h1C);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [6:0]        ctrl_q,      ctrl_d;
   logic [7:0]        count_q,     count_d;
   logic [7:0]        saddr_q,     saddr_d;
   logic [4:0]        irq_en_q,    irq_en_d;
   logic [4:0]        irq_stat_q,  irq_stat_d;
   logic              irq_q,       irq_d;
   logic              done_prev_q, done_prev_d;
   logic              active_q,    active_d;
   logic [DATA_W-1:0] rdata_q,     rdata_d;

   logic [PTR_W-1:0]  tx_wptr_q,   tx_wptr_d;
   logic [PTR_W-1:0]  tx_rptr_q,   tx_rptr_d;
   logic [CNT_W-1:0]  tx_level_q,  tx_level_d;
   logic [PTR_W-1:0]  rx_wptr_q,   rx_wptr_d;
   logic [PTR_W-1:0]  rx_rptr_q,   rx_rptr_d;
   logic [CNT_W-1:0]  rx_level_q,  rx_level_d;

   logic [7:0]        tx_mem_q [FIFO_DEPTH];
   logic [7:0]        rx_mem_q [FIFO_DEPTH];

   // ---------------------------------------------------------------------------
   // Bus decode and FIFO events
   // ---------------------------------------------------------------------------
   logic       wr_en, rd_en, flush;
   logic       tx_full, tx_empty, rx_full, rx_empty;
   logic       tx_wr, tx_push, tx_pop, tx_ovf;
   logic       rx_rd, rx_push, rx_pop, rx_unf;
   logic       tx_empty_ev, rx_avail_ev, done_rise;
   logic [4:0] w1c_mask, irq_set;
   logic [7:0] tx_head, rx_head;
   logic       rx_ready_int;
   logic       unused_wdata;

   always_comb begin
      wr_en    = chip_sel & chip_en & chip_write;
      rd_en    = chip_sel & chip_en & ~chip_write;
      flush    = wr_en & (chip_addr == A_CTRL) & wdata[7];

      tx_full  = (tx_level_q == DEPTH_L);
      tx_empty = (tx_level_q == '0);
      rx_full  = (rx_level_q == DEPTH_L);
      rx_empty = (rx_level_q == '0);

      tx_head  = tx_mem_q[tx_rptr_q];
      rx_head  = rx_mem_q[rx_rptr_q];

      // rx_ready is held low until the first edge out of reset
      rx_ready_int = active_q & ~rx_full;

      // Fullness/emptiness is judged on pre-edge state; flush wins over all
      tx_wr    = wr_en & (chip_addr == A_TXDATA);
      tx_push  = tx_wr & ~tx_full & ~flush;
      tx_ovf   = tx_wr & tx_full;
      tx_pop   = ~tx_empty & tx_ready & ~flush;

      rx_rd    = rd_en & (chip_addr == A_RXDATA);
      rx_push  = rx_valid & rx_ready_int & ~flush;
      rx_pop   = rx_rd & ~rx_empty;
      rx_unf   = rx_rd & rx_empty;

      unused_wdata = ^wdata[DATA_W-1:8];
   end

   // ---------------------------------------------------------------------------
   // FIFO pointer and level update
   // ---------------------------------------------------------------------------
   always_comb begin
      tx_wptr_d  = tx_wptr_q;
      tx_rptr_d  = tx_rptr_q;
      tx_level_d = tx_level_q;
      rx_wptr_d  = rx_wptr_q;
      rx_rptr_d  = rx_rptr_q;
      rx_level_d = rx_level_q;

      if (tx_push) tx_wptr_d = tx_wptr_q + PTR_ONE;
      if (tx_pop)  tx_rptr_d = tx_rptr_q + PTR_ONE;
      unique case ({tx_push, tx_pop})
         2'b10:   tx_level_d = tx_level_q + LVL_ONE;
         2'b01:   tx_level_d = tx_level_q - LVL_ONE;
         default: tx_level_d = tx_level_q;
      endcase

      if (rx_push) rx_wptr_d = rx_wptr_q + PTR_ONE;
      if (rx_pop)  rx_rptr_d = rx_rptr_q + PTR_ONE;
      unique case ({rx_push, rx_pop})
         2'b10:   rx_level_d = rx_level_q + LVL_ONE;
         2'b01:   rx_level_d = rx_level_q - LVL_ONE;
         default: rx_level_d = rx_level_q;
      endcase

      if (flush) begin
         tx_wptr_d  = '0;
         tx_rptr_d  = '0;
         tx_level_d = '0;
         rx_wptr_d  = '0;
         rx_rptr_d  = '0;
         rx_level_d = '0;
      end
   end

   // ---------------------------------------------------------------------------
   // Configuration registers and interrupt
   // ---------------------------------------------------------------------------
   always_comb begin
      ctrl_d      = ctrl_q;
      count_d     = count_q;
      saddr_d     = saddr_q;
      irq_en_d    = irq_en_q;
      active_d    = 1'b1;
      done_prev_d = status_reg[0];

      if (wr_en) begin
         unique case (chip_addr)
            A_CTRL:  ctrl_d   = wdata[6:0];
            A_COUNT: count_d  = wdata[7:0];
            A_SADDR: saddr_d  = wdata[7:0];
            A_IRQEN: irq_en_d = wdata[4:0];
            default: ;
         endcase
      end

      // TX_EMPTY only from a real pop taking the level 1 -> 0 (flush excluded)
      tx_empty_ev = tx_pop & ~tx_push & (tx_level_q == LVL_ONE);
      rx_avail_ev = rx_empty & (rx_level_d != '0);
      done_rise   = status_reg[0] & ~done_prev_q;
      irq_set     = {done_rise, rx_unf, tx_ovf, rx_avail_ev, tx_empty_ev};

      w1c_mask    = (wr_en && chip_addr == A_IRQST) ? wdata[4:0] : '0;
      // Set is OR-ed after the clear so a same-edge event survives the W1C
      irq_stat_d  = (irq_stat_q & ~w1c_mask) | irq_set;

      // Computed from next-state so irq is itself a flop and changes with STAT
      irq_d       = |(irq_stat_d & irq_en_d);
   end

   // ---------------------------------------------------------------------------
   // Read mux: rdata is registered and returns to zero without a read
   // ---------------------------------------------------------------------------
   always_comb begin
      logic [31:0] rd32;
      rd32 = '0;
      if (rd_en) begin
         unique case (chip_addr)
            A_CTRL:   rd32 = {25'd0, ctrl_q};
            A_COUNT:  rd32 = {24'd0, count_q};
            A_SADDR:  rd32 = {24'd0, saddr_q};
            A_STATUS: rd32 = {8'(rx_level_q), 8'(tx_level_q), 4'd0,
                              rx_empty, rx_full, tx_empty, tx_full, status_reg};
            A_RXDATA: rd32 = rx_empty ? 32'd0 : {24'd0, rx_head};
            A_IRQEN:  rd32 = {27'd0, irq_en_q};
            A_IRQST:  rd32 = {27'd0, irq_stat_q};
            default:  rd32 = '0;
         endcase
      end
      rdata_d = DATA_W'(rd32);
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge rstn) begin
      if (!rstn) begin
         ctrl_q      <= '0;
         count_q     <= '0;
         saddr_q     <= '0;
         irq_en_q    <= '0;
         irq_stat_q  <= '0;
         irq_q       <= 1'b0;
         done_prev_q <= 1'b0;
         active_q    <= 1'b0;
         rdata_q     <= '0;
         tx_wptr_q   <= '0;
         tx_rptr_q   <= '0;
         tx_level_q  <= '0;
         rx_wptr_q   <= '0;
         rx_rptr_q   <= '0;
         rx_level_q  <= '0;
      end else begin
         ctrl_q      <= ctrl_d;
         count_q     <= count_d;
         saddr_q     <= saddr_d;
         irq_en_q    <= irq_en_d;
         irq_stat_q  <= irq_stat_d;
         irq_q       <= irq_d;
         done_prev_q <= done_prev_d;
         active_q    <= active_d;
         rdata_q     <= rdata_d;
         tx_wptr_q   <= tx_wptr_d;
         tx_rptr_q   <= tx_rptr_d;
         tx_level_q  <= tx_level_d;
         rx_wptr_q   <= rx_wptr_d;
         rx_rptr_q   <= rx_rptr_d;
         rx_level_q  <= rx_level_d;
      end
   end

   // Storage needs no reset: the head is masked to zero whenever a FIFO is empty
   always_ff @(posedge CLK) begin
      if (tx_push) tx_mem_q[tx_wptr_q] <= wdata[7:0];
      if (rx_push) rx_mem_q[rx_wptr_q] <= rx_data;
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      rdata       = rdata_q;
      control_reg = {1'b0, ctrl_q};
      slave_addr  = saddr_q;
      data_count  = count_q;
      tx_valid    = ~tx_empty;
      tx_data     = tx_empty ? 8'd0 : tx_head;
      rx_ready    = rx_ready_int;
      irq         = irq_q;
   end

endmodule

// File: doc/i2c_ctrl_fifo_regs.md
Name: i2c_ctrl_fifo_regs

Overview:
Processor-facing register block for the I2C master, the next generation of the single-byte register controller. It maps control, count, slave-address and status registers onto the processor bus. It adds parametrised TX and RX byte FIFOs with a valid/ready handshake to the master, plus a maskable, sticky interrupt. It sits between the processor bus and the i2c_master core.

Parameters:
DATA_W, 32, processor data-bus width; must be >= 32; bits above 31 always read 0.
ADDR_W, 8, processor address width; only the low 8 bits are decoded, upper bits must be 0.
FIFO_DEPTH, 8, entries per FIFO; power of 2, range 2..128.
Derived CNT_W = log2(FIFO_DEPTH)+1; this is the level-counter width.

Ports:
CLK  in  1  system clock; all logic updates on posedge.
rstn  in  1  asynchronous active-low reset.
chip_sel  in  1  block select.
chip_en  in  1  access strobe; an access occurs on a cycle with chip_sel & chip_en.
chip_write  in  1  1 = write, 0 = read.
chip_addr  in  ADDR_W  byte address.
wdata  in  DATA_W  write data.
rdata  out  DATA_W  read data.
status_reg  in  8  raw status from master; bit0 = transfer done.
control_reg  out  8  control to master.
slave_addr  out  8  slave address to master.
data_count  out  8  byte count to master.
tx_data  out  8  TX FIFO head (first-word-fall-through).
tx_valid  out  1  TX FIFO not empty.
tx_ready  in  1  master accepts tx_data.
rx_data  in  8  byte received by master.
rx_valid  in  1  master offers rx_data.
rx_ready  out  1  RX FIFO not full.
irq  out  1  interrupt, OR of IRQ_STAT & IRQ_EN.

Behaviour:
- Reset (asynchronous, rstn=0): all outputs 0, both FIFOs empty, all pointers and levels 0, IRQ_EN=0, IRQ_STAT=0. Consequently tx_valid=0 and rx_ready=0 while in reset; rx_ready=1 from the first cycle after reset.
- Register map (R = readable, W = writable):
  - 0x00 CTRL (RW): bits 6:0 are stored to control_reg. Bit 7 is FLUSH, write-only and self-clearing; it always reads 0. control_reg[7]=0.
  - 0x04 COUNT (RW) -> data_count.
  - 0x08 SADDR (RW) -> slave_addr.
  - 0x0C STATUS (RO): [7:0] status_reg; [8] tx_full; [9] tx_empty; [10] rx_full; [11] rx_empty; [23:16] tx level; [31:24] rx level.
  - 0x10 TXDATA (WO): pushes wdata[7:0].
  - 0x14 RXDATA (RO): pops one byte.
  - 0x18 IRQ_EN (RW): bits [4:0].
  - 0x1C IRQ_STAT (R/W1C): bits [4:0].
  - Any other address reads 0; writes there are ignored. Writes to RO registers are ignored; reads of WO registers return 0.
- Read timing: rdata is registered at the access edge and is valid the following cycle. On any cycle without a read access, rdata is 0.
- TX FIFO push: a TXDATA write while the FIFO is not full stores the byte. A write while full (judged on pre-edge state, even if a pop happens on the same edge) is dropped and sets IRQ_STAT[2] TX_OVF.
- TX FIFO pop: occurs when tx_valid & tx_ready. A simultaneous push and pop with the FIFO neither empty-blocked nor full leaves the level unchanged. The pointers wrap modulo FIFO_DEPTH.
- RX FIFO push: occurs when rx_valid & rx_ready. The master must hold rx_data until accepted.
- RX FIFO pop: a RXDATA read while not empty returns the head and advances. A read while empty returns 0, sets IRQ_STAT[3] RX_UNF, and does not change the pointers. A simultaneous push into an empty FIFO and a pop is treated as underflow, and the pushed byte is retained.
- FLUSH: empties both FIFOs on the same edge and overrides any same-cycle push/pop on either FIFO. FLUSH does not raise TX_EMPTY.
- IRQ_STAT set sources (set on the edge the event occurs):
  - [0] TX_EMPTY: TX level goes from 1 to 0 via a pop.
  - [1] RX_AVAIL: RX level goes from 0 to nonzero.
  - [2] TX_OVF.
  - [3] RX_UNF.
  - [4] DONE: rising edge of status_reg[0], detected against a registered copy.
- IRQ_STAT clearing: writing 1 to a bit clears it. If a set event and a W1C land on the same edge, set wins.
- irq = |(IRQ_STAT & IRQ_EN). It is driven from registers only, so it is glitch-free.
- Mid-operation reset: all state is discarded immediately. No partial byte is ever presented afterwards.

Test Plan:
- Reset and register R/W: assert rstn=0 mid-traffic, release, then write 0x00=0x5A, 0x04=0x03, 0x08=0xA0 and read each back -> reads return 0x5A, 0x03, 0xA0 one cycle later; outputs match; STATUS reads 0x0000_0A00 with status_reg=0.
- TX fill and overflow (DEPTH=8, tx_ready=0): write bytes 0x01..0x09 -> level 8, tx_full=1, TX_OVF=1, byte 0x09 lost. Then raise tx_ready for 8 cycles -> tx_data sequence 0x01..0x08, TX_EMPTY set after the last pop.
- RX backpressure and underflow: master offers 9 bytes 0x10..0x18 with no reads -> rx_ready drops after 8 bytes and 0x18 is held. Then 9 RXDATA reads -> 0x10..0x17, then 0x18. A tenth read -> 0, RX_UNF=1.
- IRQ masking and W1C race: IRQ_EN=0x10, pulse status_reg[0] -> irq=1. W1C 0x10 on the same edge as a new DONE rising edge -> bit stays 1. W1C on a quiet cycle -> irq=0.
- Flush mid-transfer: 5 bytes in TX, 3 in RX, tx_ready=1, write CTRL=0x80 -> both levels 0 on that edge, tx_valid=0 next cycle, no TX_EMPTY interrupt, control_reg[7]=0.
- Wrap-around: 20 push/pop pairs with level held at 3 -> data order preserved across pointer wrap, no flags set.
